// File: rtl/exc_pkg.sv
// Shared definitions for the machine-mode exception unit.
// Holds the CSR address map, mcause codes, the trap FSM state encoding,
// the CSR write/set/clear mode encodings and the read-modify-write helper.
package exc_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    localparam logic [31:0] MCAUSE_ILLEGAL = 32'd2;
    localparam logic [31:0] MCAUSE_ECALL   = 32'd11;
    localparam logic [31:0] MCAUSE_EXT_IRQ = 32'h8000_000B;

    localparam logic [1:0] WSC_NONE  = 2'b00;
    localparam logic [1:0] WSC_WRITE = 2'b01;
    localparam logic [1:0] WSC_SET   = 2'b10;
    localparam logic [1:0] WSC_CLEAR = 2'b11;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CAUSE = 1'b1
    } state_t;

    // New CSR value for a CSRRW/CSRRS/CSRRC style access.
    function automatic logic [31:0] wsc_apply(input logic [1:0]  mode,
                                              input logic [31:0] old_val,
                                              input logic [31:0] src);
        case (mode)
            WSC_WRITE: wsc_apply = src;
            WSC_SET:   wsc_apply = old_val | src;
            WSC_CLEAR: wsc_apply = old_val & ~src;
            default:   wsc_apply = old_val;
        endcase
    endfunction

endpackage

// File: rtl/csr_file.sv
// Machine-mode CSR storage.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   addr / r_data            combinational read of the addressed CSR
//   w_en / w_data            addressed write of an already-computed value
//   trap_en / trap_epc       trap entry: save PC, stack MIE into MPIE
//   mret_en                  trap return: restore MIE from MPIE
//   cause_en / cause_val /
//   tval_val                 deferred mcause/mtval update
//   mie, mtvec, mepc         values needed by the trap control logic
module csr_file
    import exc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] addr,
    output logic [31:0] r_data,
    input  logic        w_en,
    input  logic [31:0] w_data,
    input  logic        trap_en,
    input  logic [31:0] trap_epc,
    input  logic        mret_en,
    input  logic        cause_en,
    input  logic [31:0] cause_val,
    input  logic [31:0] tval_val,
    output logic        mie,
    output logic [31:0] mtvec,
    output logic [31:0] mepc
);

    logic        mpie;
    logic [31:0] mscratch;
    logic [31:0] mcause;
    logic [31:0] mtval;

    always_comb begin
        case (addr)
            // MPP is hardwired to machine mode.
            CSR_MSTATUS:  r_data = {19'd0, 2'b11, 3'd0, mpie, 3'd0, mie, 3'd0};
            CSR_MTVEC:    r_data = mtvec;
            CSR_MSCRATCH: r_data = mscratch;
            CSR_MEPC:     r_data = mepc;
            CSR_MCAUSE:   r_data = mcause;
            CSR_MTVAL:    r_data = mtval;
            default:      r_data = 32'd0;
        endcase
    end

    // The control logic never raises trap_en, mret_en and w_en together;
    // the if/else chain just makes that precedence explicit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mie      <= 1'b0;
            mpie     <= 1'b0;
            mtvec    <= 32'd0;
            mscratch <= 32'd0;
            mepc     <= 32'd0;
            mcause   <= 32'd0;
            mtval    <= 32'd0;
        end else begin
            if (trap_en) begin
                mepc <= trap_epc;
                mpie <= mie;
                mie  <= 1'b0;
            end else if (mret_en) begin
                mie  <= mpie;
                mpie <= 1'b1;
            end else if (w_en) begin
                case (addr)
                    CSR_MSTATUS: begin
                        mie  <= w_data[MSTATUS_MIE];
                        mpie <= w_data[MSTATUS_MPIE];
                    end
                    CSR_MTVEC:    mtvec    <= {w_data[31:2], 2'b00};
                    CSR_MSCRATCH: mscratch <= w_data;
                    CSR_MEPC:     mepc     <= {w_data[31:2], 2'b00};
                    CSR_MCAUSE:   mcause   <= w_data;
                    CSR_MTVAL:    mtval    <= w_data;
                    default:      ;
                endcase
            end
            if (cause_en) begin
                mcause <= cause_val;
                mtval  <= tval_val;
            end
        end
    end

endmodule

// File: rtl/exception_unit.sv
// Machine-mode exception / interrupt / CSR unit sitting at the MEM stage.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   csr_* inputs, csr_r_data_out  CSR instruction access, old value out
//   exp_vector {illegal, ecall}, mret, interrupt   trap sources
//   epc_cur, epc_next, inst_cur   PC / instruction word for trap bookkeeping
//   redirect_mux, PC_redirect     fetch redirect on trap entry or mret
//   reg_*_flush, RegWrite_cancel  pipeline squash controls
// A trap takes two cycles: entry (redirect, save PC) then CAUSE (write
// mcause/mtval from the cause latched at entry).
module exception_unit
    import exc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_rw_in,
    input  logic [1:0]  csr_wsc_mode_in,
    input  logic        csr_w_imm_mux,
    input  logic [11:0] csr_rw_addr_in,
    input  logic [31:0] csr_w_data_reg,
    input  logic [4:0]  csr_w_data_imm,
    output logic [31:0] csr_r_data_out,
    input  logic [1:0]  exp_vector,
    input  logic        mret,
    input  logic        interrupt,
    input  logic [31:0] epc_cur,
    input  logic [31:0] epc_next,
    input  logic [31:0] inst_cur,
    output logic        redirect_mux,
    output logic [31:0] PC_redirect,
    output logic        reg_FD_flush,
    output logic        reg_DE_flush,
    output logic        reg_EM_flush,
    output logic        reg_MW_flush,
    output logic        RegWrite_cancel
);

    state_t      state_q, state_d;
    logic [31:0] cause_q, tval_q;
    logic        take_exc, take_mret, take_csr, take_irq, trap_entry, cause_en;
    logic        mie;
    logic [31:0] mtvec, mepc, csr_src, csr_new;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        take_exc  = 1'b0;
        take_mret = 1'b0;
        take_csr  = 1'b0;
        take_irq  = 1'b0;
        cause_en  = 1'b0;
        state_d   = state_q;
        case (state_q)
            S_IDLE: begin
                if (exp_vector != 2'b00)  take_exc  = 1'b1;
                else if (mret)            take_mret = 1'b1;
                else if (csr_rw_in)       take_csr  = (csr_wsc_mode_in != WSC_NONE);
                else if (interrupt && mie) take_irq = 1'b1;
                if (take_exc || take_irq) state_d = S_CAUSE;
            end
            S_CAUSE: begin
                cause_en = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign trap_entry = take_exc | take_irq;

    // Cause and faulting word are captured at entry so the CAUSE cycle is
    // independent of whatever the pipeline presents by then.
    always_ff @(posedge clk) begin
        if (trap_entry) begin
            if (take_irq) begin
                cause_q <= MCAUSE_EXT_IRQ;
                tval_q  <= 32'd0;
            end else if (exp_vector[0]) begin
                cause_q <= MCAUSE_ECALL;
                tval_q  <= 32'd0;
            end else begin
                cause_q <= MCAUSE_ILLEGAL;
                tval_q  <= inst_cur;
            end
        end
    end

    assign csr_src = csr_w_imm_mux ? {27'd0, csr_w_data_imm} : csr_w_data_reg;
    assign csr_new = wsc_apply(csr_wsc_mode_in, csr_r_data_out, csr_src);

    csr_file u_csr_file (
        .clk       (clk),
        .rst       (rst),
        .addr      (csr_rw_addr_in),
        .r_data    (csr_r_data_out),
        .w_en      (take_csr),
        .w_data    (csr_new),
        .trap_en   (trap_entry),
        .trap_epc  (take_exc ? epc_cur : epc_next),
        .mret_en   (take_mret),
        .cause_en  (cause_en),
        .cause_val (cause_q),
        .tval_val  (tval_q),
        .mie       (mie),
        .mtvec     (mtvec),
        .mepc      (mepc)
    );

    // Outputs are forced low while reset is held, even though the FSM is
    // already IDLE, so stray inputs during reset cannot redirect fetch.
    // mtvec is stored word-aligned, so it is used directly as the vector.
    assign redirect_mux    = ~rst & (trap_entry | take_mret);
    assign PC_redirect     = rst       ? 32'd0 :
                             take_mret ? mepc  :
                             trap_entry ? mtvec : 32'd0;
    assign reg_FD_flush    = redirect_mux;
    assign reg_DE_flush    = redirect_mux;
    assign reg_EM_flush    = redirect_mux;
    assign reg_MW_flush    = ~rst & take_exc;
    assign RegWrite_cancel = ~rst & take_exc;

endmodule
